// File: rtl/ts_record_serializer_pkg.sv
// ts_pkg: shared constants, frame sizing helpers and FSM state type for ts_record_serializer.
package ts_pkg;
  localparam logic [7:0] MAGIC_DEF = 8'hA5;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic int frame_bytes(input int ts_w);
    return 3 + 3 * (ts_w / 8);
  endfunction
  function automatic int cnt_w(input int ts_w);
    return $clog2(frame_bytes(ts_w));
  endfunction
endpackage

// File: rtl/ts_record_serializer.sv
// ts_record_serializer: captures timestamp records and streams them as fixed-length byte frames
// (MAGIC, SEQ, ID, start, end, delta; big-endian), flagging inconsistent deltas.
module ts_record_serializer
  import ts_pkg::*;
#(
  parameter int ID_W = 4,
  parameter int TS_W = 64,
  parameter logic [7:0] MAGIC = MAGIC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ID_W-1:0] in_id,
  input  logic [TS_W-1:0] in_start_ts,
  input  logic [TS_W-1:0] in_end_ts,
  input  logic [TS_W-1:0] in_ts,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [7:0]      m_data,
  output logic            m_last,
  output logic            busy,
  output logic            err_delta
);
  localparam int FB = frame_bytes(TS_W);
  localparam int CW = cnt_w(TS_W);
  state_t r_state, w_next;
  logic [FB*8-1:0] r_sr;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_seq;
  logic r_err;
  logic w_cap, w_fire;
  assign in_ready  = (r_state == IDLE);
  assign m_valid   = (r_state == SEND);
  assign busy      = m_valid;
  assign w_cap     = in_valid && in_ready;
  assign w_fire    = m_valid && m_ready;
  assign m_last    = m_valid && (r_cnt == CW'(FB - 1));
  // The register drains to zero after the last byte, so m_data idles at 0.
  assign m_data    = r_sr[FB*8-1 -: 8];
  assign err_delta = r_err;
  always_comb begin
    w_next = r_state;
    if (w_cap) w_next = SEND;
    else if (w_fire && m_last) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_seq <= '0;
      r_err <= 1'b0;
    end else if (w_cap) begin
      r_sr  <= {MAGIC, r_seq, 8'(in_id), in_start_ts, in_end_ts, in_ts};
      r_cnt <= '0;
      r_seq <= r_seq + 8'd1;
      // Modulo subtraction: a timestamp wrap between start and end is legal.
      if (in_ts != in_end_ts - in_start_ts) r_err <= 1'b1;
    end else if (w_fire) begin
      r_sr  <= r_sr << 8;
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_ts_record_serializer.sv
// tb_ts_record_serializer: table-driven frame checks plus back-to-back, SEQ wrap and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_ts_record_serializer;
  typedef struct {
    logic [3:0]  id;
    logic [63:0] s;
    logic [63:0] e;
    logic [63:0] t;
    bit          stall;
    logic        exp_err;
  } vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, m_ready = 0;
  logic [3:0] in_id = 0;
  logic [63:0] in_start_ts = 0, in_end_ts = 0, in_ts = 0;
  logic in_ready, m_valid, m_last, busy, err_delta;
  logic [7:0] m_data;
  int total = 0, bad = 0, nfr = 0;
  logic [7:0] cur_seq;
  logic [7:0] got[$];
  logic got_last[$];
  vec_t vecs[5];

  ts_record_serializer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_id(in_id), .in_start_ts(in_start_ts), .in_end_ts(in_end_ts), .in_ts(in_ts),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err_delta(err_delta)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] id, input logic [63:0] s, input logic [63:0] e, input logic [63:0] t);
    in_id = id; in_start_ts = s; in_end_ts = e; in_ts = t;
  endtask

  task automatic present(input logic [3:0] id, input logic [63:0] s, input logic [63:0] e,
                         input logic [63:0] t, input logic exp_err);
    int c;
    drive(id, s, e, t);
    in_valid = 1;
    for (c = 0; c < 200 && !in_ready; c++) @(negedge clk);
    if (!in_ready) chk("capture timeout", 1, 0);
    @(negedge clk);
    in_valid = 0;
    cur_seq = 8'(nfr);
    nfr++;
    chk("first byte valid", m_valid, 1);
    chk("first byte magic", m_data, 8'hA5);
    chk("err_delta after capture", err_delta, exp_err);
  endtask

  task automatic collect(input bit stall);
    bit done = 0, stalled = 0;
    logic [7:0] pd = 0;
    logic pl = 0;
    got.delete();
    got_last.delete();
    for (int c = 0; c < 3000 && !done; c++) begin
      if (m_valid) begin
        if (stalled) begin
          chk("stall data stable", m_data, pd);
          chk("stall last stable", m_last, pl);
        end
        m_ready = stall ? ($urandom_range(0, 99) < 40) : 1'b1;
        stalled = !m_ready;
        pd = m_data;
        pl = m_last;
        if (m_ready) begin
          got.push_back(m_data);
          got_last.push_back(m_last);
          if (m_last) done = 1;
        end
      end
      @(negedge clk);
    end
    m_ready = 0;
    if (!done) chk("frame timeout", 1, 0);
    chk("idle after last", m_valid, 0);
    chk("ready after last", in_ready, 1);
  endtask

  task automatic check_frame(input string name, input logic [7:0] seq, input logic [3:0] id,
                             input logic [63:0] s, input logic [63:0] e, input logic [63:0] t);
    logic [7:0] ex[$];
    int bi = -1, nl = 0;
    ex.push_back(8'hA5);
    ex.push_back(seq);
    ex.push_back({4'h0, id});
    for (int k = 7; k >= 0; k--) ex.push_back(s[8*k +: 8]);
    for (int k = 7; k >= 0; k--) ex.push_back(e[8*k +: 8]);
    for (int k = 7; k >= 0; k--) ex.push_back(t[8*k +: 8]);
    chk($sformatf("%s length", name), got.size(), 27);
    for (int i = 0; i < got.size() && i < 27; i++) begin
      if (bi < 0 && got[i] !== ex[i]) bi = i;
      if (got_last[i]) nl++;
    end
    if (bi >= 0) chk($sformatf("%s byte %0d", name, bi), got[bi], ex[bi]);
    else chk($sformatf("%s bytes", name), 0, 0);
    chk($sformatf("%s last count", name), nl, 1);
    if (got.size() > 0) chk($sformatf("%s last on final", name), got_last[got.size()-1], 1);
  endtask

  task automatic run_frame(input string name, input logic [3:0] id, input logic [63:0] s,
                           input logic [63:0] e, input logic [63:0] t, input bit stall, input logic exp_err);
    present(id, s, e, t, exp_err);
    collect(stall);
    check_frame(name, cur_seq, id, s, e, t);
  endtask

  initial begin
    vecs[0] = '{4'h3, 64'h10, 64'h25, 64'h15, 1'b0, 1'b0};
    vecs[1] = '{4'h3, 64'h10, 64'h25, 64'h15, 1'b1, 1'b0};
    vecs[2] = '{4'hF, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'h20, 1'b0, 1'b0};
    vecs[3] = '{4'h3, 64'h10, 64'h25, 64'h14, 1'b1, 1'b1};
    vecs[4] = '{4'h0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CE00, 64'h11, 1'b0, 1'b1};
    #2;
    chk("reset in_ready", in_ready, 1);
    chk("reset m_valid", m_valid, 0);
    chk("reset m_data", m_data, 0);
    chk("reset m_last", m_last, 0);
    chk("reset busy", busy, 0);
    chk("reset err_delta", err_delta, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].id, vecs[i].s, vecs[i].e, vecs[i].t,
                vecs[i].stall, vecs[i].exp_err);

    // back-to-back records with in_valid held
    drive(4'h1, 64'h100, 64'h180, 64'h80);
    in_valid = 1;
    for (int c = 0; c < 200 && !in_ready; c++) @(negedge clk);
    @(negedge clk);
    cur_seq = 8'(nfr);
    nfr++;
    drive(4'h2, 64'h200, 64'h2FF, 64'hFF);
    chk("b2b busy", busy, 1);
    collect(1'b0);
    check_frame("b2b first", cur_seq, 4'h1, 64'h100, 64'h180, 64'h80);
    @(negedge clk);
    in_valid = 0;
    cur_seq = 8'(nfr);
    nfr++;
    chk("b2b second starts", m_valid, 1);
    collect(1'b0);
    check_frame("b2b second", cur_seq, 4'h2, 64'h200, 64'h2FF, 64'hFF);

    // run to 256 frames, then the 257th must wrap SEQ to 00
    while (nfr < 256) run_frame("fill", 4'h5, 64'h1, 64'h2, 64'h1, 1'b0, 1'b1);
    run_frame("wrap", 4'h6, 64'h3, 64'h5, 64'h2, 1'b0, 1'b1);
    if (got.size() > 1) chk("seq wrap byte", got[1], 8'h00);

    // reset asserted while byte 10 is on the bus
    drive(4'h3, 64'h10, 64'h25, 64'h15);
    in_valid = 1;
    for (int c = 0; c < 200 && !in_ready; c++) @(negedge clk);
    @(negedge clk);
    in_valid = 0;
    m_ready = 1;
    repeat (9) @(negedge clk);
    chk("byte10 valid", m_valid, 1);
    chk("byte10 last", m_last, 0);
    #2 rst_n = 0;
    #1;
    chk("async m_valid", m_valid, 0);
    chk("async busy", busy, 0);
    chk("async m_last", m_last, 0);
    chk("async m_data", m_data, 0);
    chk("async err_delta", err_delta, 0);
    m_ready = 0;
    @(negedge clk);
    rst_n = 1;
    nfr = 0;
    @(negedge clk);
    chk("post reset ready", in_ready, 1);
    run_frame("post reset", 4'h3, 64'h10, 64'h25, 64'h15, 1'b0, 1'b0);
    if (got.size() > 1) chk("post reset seq", got[1], 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ts_record_serializer.md
# ts_record_serializer

Consumes the per-event timestamp record stream (ID, start timestamp, end timestamp, delta) on a valid/ready interface and serializes each record into a fixed-length byte frame for the UDP payload builder. It is the reader/consumer end of the timestamper's output record interface. It also stamps an 8-bit sequence number on each frame and flags records whose delta is inconsistent.

## Interface
Parameters:
- ID_W, 4: event ID width; legal range 1..8.
- TS_W, 64: timestamp width; must be a multiple of 8 and ≥ 8.
- MAGIC, 8'hA5: frame header byte.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; **asynchronous, active-low**.
- in_valid  in  1  record valid.
- in_ready  out  1  block can capture a record.
- in_id  in  ID_W  event ID.
- in_start_ts  in  TS_W  start timestamp.
- in_end_ts  in  TS_W  end timestamp.
- in_ts  in  TS_W  delta (end − start).
- m_valid  out  1  byte valid.
- m_ready  in  1  downstream accepts byte.
- m_data  out  8  frame byte.
- m_last  out  1  final byte of frame.
- busy  out  1  frame in progress.
- err_delta  out  1  sticky: a captured record had in_ts ≠ in_end_ts − in_start_ts.

## Operation
- NB = TS_W/8. FRAME_BYTES = 3 + 3·NB (27 at defaults).
- Frame byte order: MAGIC, SEQ, ID zero-extended to 8 bits, then start_ts, end_ts, and delta, each big-endian (MSB first). The delta is sent verbatim from in_ts.
- FSM states:
  - IDLE: in_ready=1, m_valid=0. On in_valid && in_ready:
    - load a FRAME_BYTES·8 shift register;
    - byte counter ← 0;
    - go to SEND.
  - SEND: in_ready=0, m_valid=1, m_data = shift register top byte, m_last = (counter == FRAME_BYTES−1). On m_valid && m_ready:
    - shift left 8 and increment the counter;
    - if m_last, go to IDLE.
- SEQ: 8-bit counter, reset 0. The value sent is the pre-increment value. It increments on capture and wraps 255→0.
- err_delta check at capture uses modulo 2^TS_W subtraction, so counter wrap is legal. Once set, err_delta clears only by reset. A frame with an inconsistent delta is still emitted unchanged.
- busy = (state == SEND).

## Timing
- Reset values:
  - in_ready=1; m_valid=0; m_data=0; m_last=0; busy=0; err_delta=0.
  - SEQ=0; state IDLE.
- Capture at edge N → first byte (MAGIC) valid in cycle N+1. err_delta is visible in cycle N+1.
- Stream rules:
  - While m_valid && !m_ready, m_data and m_last hold stable.
  - m_valid never drops before its handshake.
  - One byte per cycle with m_ready held high.
- After the last-byte handshake, the block is in IDLE the next cycle with in_ready=1.
  - Minimum frame period is FRAME_BYTES+1 cycles.
  - in_ready is registered state only, with no combinational path from m_ready.
- A record presented while busy waits; its inputs must be held per the valid/ready convention.
- Reset asserted mid-frame:
  - outputs drop to reset values immediately (asynchronously);
  - the partial frame is abandoned, with no m_last;
  - SEQ returns to 0.

## Structure
- Shared package ts_pkg holds:
  - MAGIC default;
  - the FRAME_BYTES(TS_W) function;
  - the state enum {IDLE, SEND};
  - byte counter width $clog2(FRAME_BYTES).
- Single module; no sub-module is natural. The shift register, counter, and FSM are all local.

## Test plan
- Record id=3, start=0x10, end=0x25, ts=0x15, m_ready=1 → 27 bytes:
  - A5, 00, 03;
  - 7×00, 10; 7×00, 25; 7×00, 15;
  - m_last on byte 27 only; err_delta=0.
- Same record, m_ready randomly toggled (≥50% low) → identical byte sequence; m_data/m_last stable across every stall; no bytes dropped or duplicated.
- Two records presented back-to-back with in_valid held → second frame SEQ=01; in_ready high exactly one cycle after first m_last handshake; one idle cycle between frames.
- Record start=0x10, end=0x25, ts=0x14 → err_delta=1 from cycle after capture; frame still ends with 0x14; err_delta remains 1 through next clean frame.
- Counter wrap: start=0xFFFF_FFFF_FFFF_FFF0, end=0x10, ts=0x20 → err_delta stays 0. After 256 frames, the 257th frame carries SEQ=00.
- rst_n pulled low during byte 10 → m_valid/busy fall asynchronously. After release, in_ready=1, and the next frame starts with A5, 00 (SEQ reset).
